// File: rtl/fdiv_pkg.sv
// Shared definitions for the sequential floating-point divider.
//   - FP_EW / FP_MW : exponent and stored-mantissa widths of the 16-bit format
//   - FP_QW         : number of quotient bits the divider produces
//   - state_t       : top-level FSM states
//   - fp_t          : field view of a packed float {sign, exponent, mantissa}
// Optional feature: FDIV_ROUND_EN enables round-half-up (one extra quotient bit).
package fdiv_pkg;

    localparam int FP_EW = 5;
    localparam int FP_MW = 10;

`ifdef FDIV_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    // Hidden bit + MW stored bits + one bit to absorb a quotient below 1.0,
    // plus a guard bit when rounding.
    localparam int FP_QW = FP_MW + 2 + RND;

    typedef enum logic [2:0] {
        IDLE,
        DIV,
        NORM,
        CHK,
        OUT
    } state_t;

    typedef struct packed {
        logic             s;
        logic [FP_EW-1:0] e;
        logic [FP_MW-1:0] m;
    } fp_t;

endpackage

// File: rtl/fdiv_div_seq.sv
// Restoring sequential divider, one quotient bit per clock.
// Computes quotient = floor(dividend * 2^(QW-1) / divisor) for normalized
// operands (both have their MSB set), so the result always fits in QW bits.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   st         : one-cycle start pulse; loads operands and clears the quotient
//   dividend   : AW-bit dividend (hidden bit included)
//   divisor    : AW-bit divisor  (hidden bit included)
//   done       : one-cycle pulse after the last quotient bit is written
//   quotient   : QW-bit result, held until the next start or reset
module div_seq #(
    parameter int AW = 11,
    parameter int QW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st,
    input  logic [AW-1:0] dividend,
    input  logic [AW-1:0] divisor,
    output logic          done,
    output logic [QW-1:0] quotient
);

    localparam int CW = $clog2(QW);

    // The partial remainder is always below the divisor (or the initial
    // dividend), so AW bits suffice after a step; the extra bit holds the
    // doubled value before the next compare.
    logic [AW:0]   rem;
    logic [AW-1:0] dvs;
    logic [CW-1:0] cnt;
    logic          busy;
    logic          ge;
    logic [AW:0]   diff;

    always_comb begin
        ge   = rem >= {1'b0, dvs};
        diff = rem - {1'b0, dvs};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (st) begin
                rem      <= {1'b0, dividend};
                dvs      <= divisor;
                cnt      <= '0;
                busy     <= 1'b1;
                quotient <= '0;
            end else if (busy) begin
                quotient <= {quotient[QW-2:0], ge};
                rem      <= ge ? {diff[AW-1:0], 1'b0} : {rem[AW-1:0], 1'b0};
                cnt      <= cnt + 1'b1;
                if (cnt == CW'(QW - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fdiv.sv
// Sequential 16-bit floating-point divider: f = f1 / f2.
// Format: sign[15], two's-complement exponent[14:10], mantissa[9:0] with a
// hidden leading 1. Exponent overflow/underflow flushes f to zero and sets v.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   enable     : start request, only looked at in IDLE; also keeps the result
//                presented in OUT until it drops
//   f1, f2     : dividend and divisor
//   f, v, done : quotient, range-error flag, result-ready flag
// Optional feature: define FDIV_ROUND_EN for round-half-up instead of
// truncation (divider produces one extra quotient bit).
module fdiv
    import fdiv_pkg::*;
#(
    parameter int EW = FP_EW,
    parameter int MW = FP_MW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [EW+MW:0]    f1,
    input  logic [EW+MW:0]    f2,
    output logic [EW+MW:0]    f,
    output logic              v,
    output logic              done
);

    localparam int QW = MW + 2 + RND;
    localparam logic [EW:0] ONE_E = (EW+1)'(1);

    state_t          state, state_nx;
    fp_t             a, b;
    logic            st;
    logic            div_done;
    logic [QW-1:0]   q;
    logic [EW:0]     ee, ee_raw, n_ee;
    logic [MW-1:0]   mant, n_mant;
    logic            ovf;

    // Start pulse is issued the cycle after the operands land in a/b, so the
    // divider only ever sees latched values.
    div_seq #(
        .AW (MW + 1),
        .QW (QW)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .st       (st),
        .dividend ({1'b1, a.m}),
        .divisor  ({1'b1, b.m}),
        .done     (div_done),
        .quotient (q)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // DIV covers the divider load, its quotient-bit cycles and the done pulse.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (enable)   state_nx = DIV;
            DIV:     if (div_done) state_nx = NORM;
            NORM:    state_nx = CHK;
            CHK:     state_nx = OUT;
            OUT:     if (!enable)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign ee_raw = {a.e[EW-1], a.e} - {b.e[EW-1], b.e};

`ifdef FDIV_ROUND_EN
    logic [MW-1:0] pre_mant;
    logic [EW:0]   pre_ee;
    logic          rb;
    logic [MW:0]   sum;

    always_comb begin
        if (q[QW-1]) begin
            pre_mant = q[QW-2:2];
            rb       = q[1];
            pre_ee   = ee_raw;
        end else begin
            pre_mant = q[QW-3:1];
            rb       = q[0];
            pre_ee   = ee_raw - ONE_E;
        end
        sum = {1'b0, pre_mant} + {{MW{1'b0}}, rb};
        // Carry out of an all-ones mantissa rolls over to the next binade.
        if (sum[MW]) begin
            n_mant = '0;
            n_ee   = pre_ee + ONE_E;
        end else begin
            n_mant = sum[MW-1:0];
            n_ee   = pre_ee;
        end
    end
`else
    always_comb begin
        if (q[QW-1]) begin
            n_mant = q[QW-2:1];
            n_ee   = ee_raw;
        end else begin
            n_mant = q[QW-3:0];
            n_ee   = ee_raw - ONE_E;
        end
    end
`endif

    // Representable range is [-16,15]: the two top bits of the 6-bit
    // exponent must agree.
    assign ovf = ee[EW] ^ ee[EW-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            a    <= '0;
            b    <= '0;
            st   <= 1'b0;
            ee   <= '0;
            mant <= '0;
            f    <= '0;
            v    <= 1'b0;
            done <= 1'b0;
        end else begin
            st <= 1'b0;
            case (state)
                IDLE: if (enable) begin
                    a  <= f1;
                    b  <= f2;
                    st <= 1'b1;
                end
                NORM: begin
                    ee   <= n_ee;
                    mant <= n_mant;
                end
                CHK: begin
                    v    <= ovf;
                    f    <= ovf ? '0 : {a.s ^ b.s, ee[EW-1:0], mant};
                    done <= 1'b1;
                end
                OUT: if (!enable) done <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv.sv
// Directed self-checking bench for fdiv.
module tb_fdiv;

`ifdef FDIV_ROUND_EN
    localparam int LAT = 17;
    localparam logic [15:0] R_125_15 = 16'h7EAB;
    localparam logic [15:0] R_1_2047 = 16'h7C01;
`else
    localparam int LAT = 16;
    localparam logic [15:0] R_125_15 = 16'h7EAA;
    localparam logic [15:0] R_1_2047 = 16'h7C00;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] f1, f2, f;
    logic        v, done;

    int tests = 0;
    int fails = 0;

    fdiv dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .f1     (f1),
        .f2     (f2),
        .f      (f),
        .v      (v),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Drives one operation (optionally aligning to a falling edge first),
    // scrambles the inputs after the latch edge, counts edges to done,
    // then lets the FSM return to IDLE.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit align,
                          output int edges, output logic [15:0] rf, output logic rv);
        if (align) @(negedge clk);
        f1 = a; f2 = b; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0; f1 = ~a; f2 = ~b;
        edges = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                edges = i;
                break;
            end
        end
        rf = f; rv = v;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; f1 = 16'h0; f2 = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (f !== 16'h0000) begin fails++; $display("FAIL reset_f: got %h want 0000", f); end
        tests++; if (v !== 1'b0) begin fails++; $display("FAIL reset_v: got %b want 0", v); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_normal();
        logic [15:0] va[6], vb[6], vf[6];
        int e; logic [15:0] rf; logic rv;
        va = '{16'h0800, 16'h8000, 16'h0600, 16'h8600, 16'h0100, 16'h0000};
        vb = '{16'h0400, 16'h0200, 16'h0200, 16'h8200, 16'h0200, 16'h03FF};
        vf = '{16'h0400, 16'hFD55, 16'h0400, 16'h0400, R_125_15, R_1_2047};
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], 1'b1, e, rf, rv);
            tests++; if (e !== LAT) begin fails++; $display("FAIL normal%0d_latency: got %0d want %0d", i, e, LAT); end
            tests++; if (rf !== vf[i]) begin fails++; $display("FAIL normal%0d_f: got %h want %h", i, rf, vf[i]); end
            tests++; if (rv !== 1'b0) begin fails++; $display("FAIL normal%0d_v: got %b want 0", i, rv); end
        end
    endtask

    // Exponent range edges: in-range limits, overflow, underflow, and
    // normalization moving the exponent across a limit.
    task automatic test_range();
        logic [15:0] va[6], vb[6], vf[6]; logic vv[6];
        int e; logic [15:0] rf; logic rv;
        va = '{16'h3C00, 16'h4000, 16'h3C00, 16'h4000, 16'h4000, 16'h3C00};
        vb = '{16'h0000, 16'h0000, 16'h4000, 16'h0400, 16'h0200, 16'h7E00};
        vf = '{16'h3C00, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h3D55};
        vv = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b1,     1'b0};
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], 1'b1, e, rf, rv);
            tests++; if (e !== LAT) begin fails++; $display("FAIL range%0d_latency: got %0d want %0d", i, e, LAT); end
            tests++; if (rf !== vf[i]) begin fails++; $display("FAIL range%0d_f: got %h want %h", i, rf, vf[i]); end
            tests++; if (rv !== vv[i]) begin fails++; $display("FAIL range%0d_v: got %b want %b", i, rv, vv[i]); end
        end
    endtask

    task automatic test_abort();
        int e; logic [15:0] rf; logic rv;
        @(negedge clk);
        f1 = 16'h0600; f2 = 16'h0200; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        tests++; if (f !== 16'h0000) begin fails++; $display("FAIL abort_f: got %h want 0000", f); end
        tests++; if (v !== 1'b0) begin fails++; $display("FAIL abort_v: got %b want 0", v); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL abort_done: got %b want 0", done); end
        @(negedge clk); reset = 1'b0;
        run_op(16'h0800, 16'h0400, 1'b0, e, rf, rv);
        tests++; if (e !== LAT) begin fails++; $display("FAIL abort_restart_latency: got %0d want %0d", e, LAT); end
        tests++; if (rf !== 16'h0400) begin fails++; $display("FAIL abort_restart_f: got %h want 0400", rf); end
        tests++; if (rv !== 1'b0) begin fails++; $display("FAIL abort_restart_v: got %b want 0", rv); end
    endtask

    task automatic test_hold();
        int e;
        @(negedge clk);
        f1 = 16'h8000; f2 = 16'h0200; enable = 1'b1;
        @(negedge clk);
        f1 = 16'h3C00; f2 = 16'h4000;
        e = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 4) begin f1 = 16'h0100; f2 = 16'h03FF; end
            if (done === 1'b1) begin
                e = i;
                break;
            end
        end
        tests++; if (e !== LAT) begin fails++; $display("FAIL hold_latency: got %0d want %0d", e, LAT); end
        tests++; if (f !== 16'hFD55) begin fails++; $display("FAIL hold_f: got %h want fd55", f); end
        tests++; if (v !== 1'b0) begin fails++; $display("FAIL hold_v: got %b want 0", v); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++; if ({done, f} !== {1'b1, 16'hFD55}) begin
                fails++; $display("FAIL hold_keep%0d: got done=%b f=%h want done=1 f=fd55", i, done, f);
            end
        end
        @(negedge clk); enable = 1'b0;
        @(posedge clk); #1;
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL hold_release_done: got %b want 0", done); end
        tests++; if (f !== 16'hFD55) begin fails++; $display("FAIL hold_release_f: got %h want fd55", f); end
        tests++; if (v !== 1'b0) begin fails++; $display("FAIL hold_release_v: got %b want 0", v); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_range();
        test_abort();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
